// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_bus_arbiter_if                                                   |
// | Per-master request/response bundle for the memory/peripheral arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          err;

    modport master (output req, we, addr, wdata, input rdata, ack, err);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_bus_arbiter                                                      |
// | Round-robin two-master arbiter for the unified memory port and the   |
// | peripheral bus. Optional macro ARB_PERI_TIMEOUT_EN aborts stalled    |
// | peripheral accesses after TIMEOUT cycles.                            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_bus_arbiter #(
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter int            MEM_LAT   = 1,
    parameter logic [AW-1:0] PERI_BASE = 32'h1001_0000,
    parameter int            TIMEOUT   = 16
) (
    input  wire logic          CLK,
    input  wire logic          CLR,
    mem_bus_arbiter_if.slave   m0,
    mem_bus_arbiter_if.slave   m1,
    output logic               mem_cs,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  wire logic [DW-1:0] mem_rdata,
    output logic               peri_cs,
    output logic               peri_we,
    output logic [AW-1:0]      peri_addr,
    output logic [DW-1:0]      peri_wdata,
    input  wire logic [DW-1:0] peri_rdata,
    input  wire logic          peri_ack,
    output logic               busy,
    output logic               grant
);

    if (MEM_LAT < 0 || MEM_LAT > 15 || TIMEOUT < 1) begin : g_param_check
        $error("mem_bus_arbiter: MEM_LAT must be 0..15 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        PERI = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_id;
    logic          r_we;
    logic          r_grant;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic [3:0]    r_wait;

    logic          w_any;
    logic          w_pick;
    logic [AW-1:0] w_sel_addr;
    logic          w_sel_peri;
    logic          w_mem_last;
    logic          w_cap;
    logic [DW-1:0] w_cap_data;

`ifdef ARB_PERI_TIMEOUT_EN
    localparam int TCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [TCW-1:0] r_tcnt;
    logic           r_err;
    logic           w_tmo;
`endif

    // With both requesting, the master that did not win last time goes next.
    assign w_any      = m0.req | m1.req;
    assign w_pick     = (m0.req && m1.req) ? ~r_grant : ~m0.req;
    assign w_sel_addr = w_pick ? m1.addr : m0.addr;
    assign w_sel_peri = (w_sel_addr >= PERI_BASE);
    assign w_mem_last = (r_wait == 4'(MEM_LAT));

    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign peri_addr  = r_addr;
    assign peri_wdata = r_wdata;
    assign busy       = (r_state != IDLE);
    assign grant      = r_grant;
    assign m0.rdata   = r_rdata0;
    assign m1.rdata   = r_rdata1;

`ifdef ARB_PERI_TIMEOUT_EN
    assign m0.err = (r_state == RESP) && !r_id && r_err;
    assign m1.err = (r_state == RESP) &&  r_id && r_err;
`else
    assign m0.err = 1'b0;
    assign m1.err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        peri_cs    = 1'b0;
        peri_we    = 1'b0;
        w_cap      = 1'b0;
        w_cap_data = mem_rdata;
        m0.ack     = 1'b0;
        m1.ack     = 1'b0;
`ifdef ARB_PERI_TIMEOUT_EN
        w_tmo      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = w_sel_peri ? PERI : MEM;
                end
            end
            MEM: begin
                mem_cs = 1'b1;
                mem_we = r_we;
                if (w_mem_last) begin
                    w_cap  = !r_we;
                    w_next = RESP;
                end
            end
            PERI: begin
                peri_cs    = 1'b1;
                peri_we    = r_we;
                w_cap_data = peri_rdata;
                if (peri_ack) begin
                    w_cap  = !r_we;
                    w_next = RESP;
                end
`ifdef ARB_PERI_TIMEOUT_EN
                // An ack on the last counted cycle takes the branch above.
                else if (r_tcnt == TCW'(TIMEOUT - 1)) begin
                    w_tmo      = 1'b1;
                    w_cap      = 1'b1;
                    w_cap_data = DW'(32'hDEAD_BEEF);
                    w_next     = RESP;
                end
`endif
            end
            RESP: begin
                m0.ack = ~r_id;
                m1.ack = r_id;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_id     <= 1'b0;
            r_we     <= 1'b0;
            r_grant  <= 1'b1;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_wait   <= '0;
`ifdef ARB_PERI_TIMEOUT_EN
            r_tcnt   <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE && w_any) begin
                r_id    <= w_pick;
                r_grant <= w_pick;
                r_we    <= w_pick ? m1.we : m0.we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_pick ? m1.wdata : m0.wdata;
                r_wait  <= '0;
`ifdef ARB_PERI_TIMEOUT_EN
                r_tcnt  <= '0;
                r_err   <= 1'b0;
`endif
            end
            if (r_state == MEM) begin
                r_wait <= r_wait + 4'd1;
            end
`ifdef ARB_PERI_TIMEOUT_EN
            if (r_state == PERI) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end
`endif
            if (w_cap) begin
                if (r_id) begin
                    r_rdata1 <= w_cap_data;
                end else begin
                    r_rdata0 <= w_cap_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single unified memory port and the peripheral bus of the multicycle MIPS core between two masters: M0 (the CPU datapath's memory-access path) and M1 (the program loader / debug writer). Grants one transaction at a time with round-robin fairness and decodes each address to internal memory or the peripheral space. Sequences memory wait states and the peripheral handshake, then returns read data with a one-cycle acknowledge. Sits between the control-unit-driven datapath address mux and the memory/peripheral blocks.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, memory wait states (0..15); mem_cs held MEM_LAT+1 cycles
- PERI_BASE, 32'h1001_0000, addresses >= PERI_BASE decode to the peripheral bus
- TIMEOUT, 16, peripheral ack limit in cycles (used only with the macro)

- CLK  in  1  clock, all logic on rising edge
- CLR  in  1  reset, synchronous, active-high
- m0_req / m1_req  in  1  transaction request, level
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  byte address
- m0_wdata / m1_wdata  in  DW  write data
- m0_rdata / m1_rdata  out  DW  registered read data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  pulses with ack on peripheral timeout
- mem_cs, mem_we  out  1  memory select / write enable
- mem_addr  out  AW;  mem_wdata  out  DW;  mem_rdata  in  DW
- peri_cs, peri_we  out  1  peripheral select / write enable
- peri_addr  out  AW;  peri_wdata  out  DW;  peri_rdata  in  DW;  peri_ack  in  1
- busy  out  1  high in any state other than IDLE
- grant  out  1  id of current/last granted master

## Operation
- States: IDLE, MEM, PERI, RESP. Reset -> IDLE.
- IDLE: sample m0_req/m1_req. One requester -> grant it. Both -> grant the one not equal to last grant (round-robin). Latch addr, we, wdata, id; update grant. Next: MEM if addr < PERI_BASE (unsigned), else PERI. No request -> stay.
- MEM: mem_cs=1, mem_we=latched we, mem_addr/mem_wdata from latch; wait counter counts 0..MEM_LAT; on final cycle capture mem_rdata (reads only) and go RESP.
- PERI: peri_cs/peri_we/peri_addr/peri_wdata driven from latch until peri_ack=1; capture peri_rdata on that cycle (reads only); go RESP.
- RESP: ack of granted master = 1 for exactly one cycle, its rdata updated (reads) or unchanged (writes); the other master's outputs untouched. Next: IDLE.
- Request deassertion after grant is ignored; the transaction completes.
- Masters present their next request (or drop req) in the cycle after ack; IDLE re-samples there.
- Unselected bus outputs (cs, we) are 0; addr/wdata hold latched values.

## Timing
- Reset values: all cs/we/ack/err = 0, rdata = 0, mem/peri addr and wdata = 0, busy = 0, grant = 1 (so M0 wins the first contention), state IDLE.
- CLR mid-transaction: next cycle state IDLE, all cs deasserted, no ack issued, in-flight transaction discarded.
- Memory transaction: req sampled in cycle N (IDLE) -> mem_cs cycles N+1..N+1+MEM_LAT -> ack in cycle N+2+MEM_LAT. MEM_LAT=0 -> ack at N+2.
- Peripheral transaction: peri_cs from N+1; peri_ack in cycle K -> ack in K+1.
- Back-to-back minimum: one IDLE cycle between transactions; sustained memory throughput one transaction per MEM_LAT+3 cycles.
- Both masters continuously requesting -> grants strictly alternate.

## Configuration
- Macro ARB_PERI_TIMEOUT_EN.
- Defined: cycle counter runs in PERI; if peri_ack not seen after TIMEOUT cycles of peri_cs, abort to RESP with rdata = 32'hDEAD_BEEF (reads and writes alike) and err pulsed with ack. peri_ack arriving on the final counted cycle wins (normal completion).
- Undefined: PERI waits indefinitely; m0_err/m1_err tied 0; no counter logic.

## Test plan
- MEM_LAT=1, M0 reads 0x0000_0010 with mem_rdata=0x1234_5678 -> mem_cs 2 cycles, m0_ack at N+3, m0_rdata=0x1234_5678, m1_ack stays 0.
- M0 and M1 both request in the same cycle after reset -> M0 granted first, then M1; with both held, grants alternate M0,M1,M0,M1.
- M1 writes 0xCAFE_0001 to 0x1001_0004, peri_ack after 3 cycles -> peri_cs/peri_we high 3 cycles with peri_wdata=0xCAFE_0001, mem_cs never high, m1_ack next cycle, m1_rdata unchanged.
- CLR asserted during MEM cycle -> next cycle mem_cs=0, busy=0, no ack; subsequent request completes normally with grant order restarted at M0.
- With ARB_PERI_TIMEOUT_EN, M0 reads 0x1001_0000, peri_ack never asserted -> after 16 cycles m0_ack=1, m0_err=1, m0_rdata=0xDEAD_BEEF; without macro, busy stays 1 and no ack.
- Address 0x1000_FFFC -> MEM path; 0x1001_0000 -> PERI path (decode boundary).
